uart_receiver: RTL

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// UART receiver with 16x oversampling, 7/8 data bits, optional odd/even
// parity, and one or two stop bits. The line is brought into the baud_out
// domain through a two-flop synchronizer, and every decision uses that
// synchronized value.
//
// Ports:
//   baud_out     : clock at OVERSAMPLE x bit rate
//   rst          : async active-low reset
//   data_tx      : serial line, idle high
//   data_length  : 0 = 7 data bits, 1 = 8 data bits
//   stop_bits    : 0 = one stop bit, 1 = two stop bits
//   parity_type  : 2'b01 odd, 2'b10 even, otherwise no parity bit
//   data_out     : last received word, LSB first on the line
//   rx_done      : one-cycle pulse when a frame completes
//   rx_active    : high while a frame is being received
//   parity_error : parity mismatch on the last completed frame
//   stop_error   : a stop bit was sampled low on the last completed frame
module uart_receiver #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       baud_out,
  input  logic       rst,
  input  logic       data_tx,
  input  logic       data_length,
  input  logic       stop_bits,
  input  logic [1:0] parity_type,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       rx_active,
  output logic       parity_error,
  output logic       stop_error
);

  localparam int unsigned CNT_W    = $clog2(OVERSAMPLE);
  localparam int unsigned MID_TICK = OVERSAMPLE / 2 - 1;
  localparam int unsigned END_TICK = OVERSAMPLE - 1;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, DONE, WAIT_HIGH
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             stop_cnt_q, stop_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_bit_q, par_bit_d;
  logic             frame_serr_q, frame_serr_d;
  logic             cfg_len_q, cfg_len_d;
  logic             cfg_sb_q, cfg_sb_d;
  logic [1:0]       cfg_par_q, cfg_par_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             rx_done_q, rx_done_d;
  logic             rx_active_q, rx_active_d;
  logic             par_err_q, par_err_d;
  logic             stop_err_q, stop_err_d;

  logic             rx_c;
  logic             par_en_c;
  logic [7:0]       word_c;
  logic             par_x_c;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge baud_out or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= data_tx;
      sync2_q <= sync1_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge baud_out or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      shreg_q      <= '0;
      par_bit_q    <= 1'b0;
      frame_serr_q <= 1'b0;
      cfg_len_q    <= 1'b0;
      cfg_sb_q     <= 1'b0;
      cfg_par_q    <= '0;
      data_out_q   <= '0;
      rx_done_q    <= 1'b0;
      rx_active_q  <= 1'b0;
      par_err_q    <= 1'b0;
      stop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      shreg_q      <= shreg_d;
      par_bit_q    <= par_bit_d;
      frame_serr_q <= frame_serr_d;
      cfg_len_q    <= cfg_len_d;
      cfg_sb_q     <= cfg_sb_d;
      cfg_par_q    <= cfg_par_d;
      data_out_q   <= data_out_d;
      rx_done_q    <= rx_done_d;
      rx_active_q  <= rx_active_d;
      par_err_q    <= par_err_d;
      stop_err_q   <= stop_err_d;
    end
  end

  // Shift register fills from bit 7, so a 7-bit word sits in [7:1].
  assign rx_c     = sync2_q;
  assign par_en_c = (cfg_par_q == 2'b01) || (cfg_par_q == 2'b10);
  assign word_c   = cfg_len_q ? shreg_q : {1'b0, shreg_q[7:1]};
  assign par_x_c  = (^word_c) ^ par_bit_q;

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    shreg_d      = shreg_q;
    par_bit_d    = par_bit_q;
    frame_serr_d = frame_serr_q;
    cfg_len_d    = cfg_len_q;
    cfg_sb_d     = cfg_sb_q;
    cfg_par_d    = cfg_par_q;
    data_out_d   = data_out_q;
    rx_done_d    = 1'b0;
    par_err_d    = par_err_q;
    stop_err_d   = stop_err_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_c) begin
          state_d   = START;
          cfg_len_d = data_length;
          cfg_sb_d  = stop_bits;
          cfg_par_d = parity_type;
        end
      end
      START: begin
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_W'(MID_TICK)) begin
          cnt_d = '0;
          if (rx_c) begin
            state_d = IDLE;
          end else begin
            state_d      = DATA;
            bit_cnt_d    = '0;
            stop_cnt_d   = 1'b0;
            shreg_d      = '0;
            par_bit_d    = 1'b0;
            frame_serr_d = 1'b0;
          end
        end
      end
      DATA: begin
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_W'(END_TICK)) begin
          cnt_d     = '0;
          shreg_d   = {rx_c, shreg_q[7:1]};
          bit_cnt_d = 3'(bit_cnt_q + 1'b1);
          if (bit_cnt_q == (cfg_len_q ? 3'd7 : 3'd6)) begin
            state_d = par_en_c ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_W'(END_TICK)) begin
          cnt_d     = '0;
          par_bit_d = rx_c;
          state_d   = STOP;
        end
      end
      STOP: begin
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_W'(END_TICK)) begin
          cnt_d = '0;
          if (!rx_c) frame_serr_d = 1'b1;
          if (cfg_sb_q && !stop_cnt_q) stop_cnt_d = 1'b1;
          else                         state_d    = DONE;
        end
      end
      DONE: begin
        state_d    = frame_serr_q ? WAIT_HIGH : IDLE;
        data_out_d = word_c;
        stop_err_d = frame_serr_q;
        rx_done_d  = 1'b1;
        unique case (cfg_par_q)
          2'b01:   par_err_d = ~par_x_c;
          2'b10:   par_err_d = par_x_c;
          default: par_err_d = 1'b0;
        endcase
      end
      WAIT_HIGH: begin
        // A held-low line after a framing error must not look like a new start.
        if (rx_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rx_active_d = (state_d == START) || (state_d == DATA) ||
                  (state_d == PARITY) || (state_d == STOP);
  end

  assign data_out     = data_out_q;
  assign rx_done      = rx_done_q;
  assign rx_active    = rx_active_q;
  assign parity_error = par_err_q;
  assign stop_error   = stop_err_q;

endmodule
